// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
package rf_pkg;

  // Clear sequencer state: CLEAR walks the bank writing zeros, READY serves traffic.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // Architectural zero register; never written, never pending, always reads 0.
  localparam int unsigned RF_ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by write,
// with a combinational lookup per read port for RAW hazard detection.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned WORDS       = 32,
  parameter int unsigned SELECT_SIZE = $clog2(WORDS),
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              set_i,
  input  logic [SELECT_SIZE-1:0]            set_idx_i,
  input  logic                              clr_i,
  input  logic [SELECT_SIZE-1:0]            clr_idx_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0] rd_sel_i,
  output logic [READ_PORTS-1:0]             busy_o
);

  localparam logic [SELECT_SIZE-1:0] ZeroSel = SELECT_SIZE'(RF_ZERO_REG);

  logic [WORDS-1:0] pend_q, pend_d;

  // Next pending vector: a reserve in the same cycle as a write wins (new producer).
  always_comb begin
    pend_d = pend_q;
    if (clr_i) begin
      pend_d[clr_idx_i] = 1'b0;
    end
    if (set_i) begin
      pend_d[set_idx_i] = 1'b1;
    end
    pend_d[RF_ZERO_REG] = 1'b0;
  end

  // Pending vector register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
    logic [SELECT_SIZE-1:0] sel;
    logic                   masked;

    assign sel = rd_sel_i[p*SELECT_SIZE +: SELECT_SIZE];

    // A same-cycle write resolves the hazard (data is forwarded) unless a same-cycle
    // reserve re-claims the register.
    assign masked = (BYPASS != 0) && clr_i && (clr_idx_i == sel) &&
                    !(set_i && (set_idx_i == sel));

    assign busy_o[p] = (sel != ZeroSel) && pend_q[sel] && !masked;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write bypass, pending-write scoreboard and a
// hardware clear sequencer that zeroes the bank after reset.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORDS       = 32,
  parameter int unsigned SELECT_SIZE = $clog2(WORDS),
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  output logic                              ready_o,
  input  logic                              reg_we_i,
  input  logic [SELECT_SIZE-1:0]            reg_dst_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0] rd_sel_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data_o,
  input  logic                              reserve_i,
  input  logic [SELECT_SIZE-1:0]            reserve_dst_i,
  output logic [READ_PORTS-1:0]             busy_o
);

  localparam logic [SELECT_SIZE-1:0] ZeroSel = SELECT_SIZE'(RF_ZERO_REG);
  localparam logic [SELECT_SIZE-1:0] LastSel = SELECT_SIZE'(WORDS - 1);
  localparam logic [SELECT_SIZE-1:0] OneSel  = SELECT_SIZE'(1);

  rf_state_t              state_q, state_d;
  logic [SELECT_SIZE-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0]  bank_q [WORDS];

  logic                   is_ready;
  logic                   wr_en;
  logic                   rsv_en;
  logic [READ_PORTS-1:0]  sb_busy;

  assign is_ready = (state_q == READY);
  // Reset dominates every other input, so it also suppresses same-cycle writes/reserves.
  assign wr_en    = is_ready && !rst_i && !reg_we_i && (reg_dst_i != ZeroSel);
  assign rsv_en   = is_ready && !rst_i && reserve_i && (reserve_dst_i != ZeroSel);
  assign ready_o  = is_ready;

  // Clear sequencer next state: step the index each cycle, leave after the last register.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + OneSel;
        if (clr_idx_q == LastSel) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Sequencer state register; x0 is never stored so clearing starts at index 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= OneSel;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Bank storage: zero-fill while clearing, otherwise accept the architectural write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        bank_q[clr_idx_q] <= '0;
      end else if (wr_en) begin
        bank_q[reg_dst_i] <= data_i;
      end
    end
  end

  rf_scoreboard #(
    .WORDS      (WORDS),
    .SELECT_SIZE(SELECT_SIZE),
    .READ_PORTS (READ_PORTS),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (rsv_en),
    .set_idx_i(reserve_dst_i),
    .clr_i    (wr_en),
    .clr_idx_i(reg_dst_i),
    .rd_sel_i (rd_sel_i),
    .busy_o   (sb_busy)
  );

  assign busy_o = sb_busy & {READ_PORTS{is_ready}};

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [SELECT_SIZE-1:0] sel;
    logic [DATA_WIDTH-1:0]  rdata;

    assign sel = rd_sel_i[p*SELECT_SIZE +: SELECT_SIZE];

    // Read mux: zero while clearing or for x0, forwarded write data, else bank contents.
    always_comb begin
      rdata = '0;
      if (is_ready && (sel != ZeroSel)) begin
        if ((BYPASS != 0) && wr_en && (reg_dst_i == sel)) begin
          rdata = data_i;
        end else begin
          rdata = bank_q[sel];
        end
      end
    end

    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file with write bypass, a pending-write scoreboard and a hardware clear sequencer, successor to the fixed 2-read/1-write 32x32 bank. Sits in the decode/register-read stage of the RV32I core and feeds the operand latches. The pipelined control path uses it to detect RAW hazards against in-flight writes. x0 is hard-wired to zero on every path.

## Interface
- DATA_WIDTH, 32, register width in bits
- WORDS, 32, number of registers (power of two, >= 4)
- SELECT_SIZE, $clog2(WORDS), register select width
- READ_PORTS, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns old contents
- clk_i  input  1  clock; one clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- ready_o  output  1  high once the clear sequence has finished
- reg_we_i  input  1  write enable, active low
- reg_dst_i  input  SELECT_SIZE  write destination
- data_i  input  DATA_WIDTH  write data
- rd_sel_i  input  READ_PORTS*SELECT_SIZE  packed read selects, port p at [p*SELECT_SIZE +: SELECT_SIZE]
- rd_data_o  output  READ_PORTS*DATA_WIDTH  packed read data, same packing
- reserve_i  input  1  mark reserve_dst_i as pending (instruction issued, write outstanding)
- reserve_dst_i  input  SELECT_SIZE  register to reserve
- busy_o  output  READ_PORTS  bit p high when rd_sel of port p is pending

## Operation
- States: CLEAR, READY. rst_i high at an edge: state <= CLEAR, clear index <= 1, all scoreboard bits <= 0, ready_o <= 0. rst_i has priority over every other input.
- CLEAR: each cycle bank[idx] <= 0, idx++. After writing WORDS-1, state <= READY. Writes and reserves ignored. All rd_data_o = 0, busy_o = 0.
- READY: write when reg_we_i == 0 and reg_dst_i != 0. bank[reg_dst_i] <= data_i. Scoreboard bit for reg_dst_i cleared.
- Reserve when reserve_i == 1 and reserve_dst_i != 0: scoreboard bit set.
- Simultaneous write and reserve to the same register: reserve wins, bit ends set (new producer).
- Reads are combinational. rd_sel == 0 returns 0. With BYPASS=1, a read matching an active write (same cycle, dst != 0) returns data_i. Otherwise it returns bank contents.
- busy_o[p] = scoreboard[rd_sel_p]. With BYPASS=1, a same-cycle write to that register masks busy to 0 unless a same-cycle reserve targets it. busy for x0 is always 0.
- Writes to x0 and reserves of x0 are silently dropped.

## Timing
- Reset values: ready_o = 0, busy_o = 0, rd_data_o = 0, state CLEAR, scoreboard all 0.
- Clear latency: with rst_i deasserted, ready_o rises after WORDS-1 rising edges. For WORDS=32 that is 31 cycles.
- rst_i reasserted mid-clear restarts at idx = 1. rst_i reasserted in READY re-enters CLEAR; bank contents are rewritten to 0.
- Write latency: visible through the bank on the cycle after the edge. Visible the same cycle via bypass when BYPASS=1.
- Reserve latency: busy_o reflects a reserve from the cycle after the edge. A same-cycle reserve does not raise busy combinationally.
- No back-pressure; every READY cycle accepts one write and one reserve.

## Structure
- Shared package rf_pkg: rf_state_t enum (CLEAR, READY) and the RF_ZERO_REG constant.
- Sub-module rf_scoreboard holds the WORDS-bit pending vector with set/clear/priority logic and a READ_PORTS lookup. Bank, bypass muxes and the clear sequencer live in register_file_mp.
- Read ports are generated with a generate loop over READ_PORTS.

## Test plan
- Reset, then hold rst_i low: ready_o stays 0 for exactly 31 cycles, then goes to 1. Every register then reads 0.
- Write x5 = 0xBEEFDEAD with port0 sel=5 in the same cycle. BYPASS=1 gives port0 = 0xBEEFDEAD that cycle; BYPASS=0 gives 0 that cycle and 0xBEEFDEAD the next.
- Write x0 = 0xFFFFFFFF and reserve x0: port reads of x0 return 0 and busy stays 0.
- Reserve x7, then read x7 on port1: busy_o[1] = 1. Write x7 = 0x12 at cycle +3: busy_o[1] = 0 with data 0x12.
- Write and reserve x9 in the same cycle: busy_o is set on the next cycle and x9 = written data.
- Assert rst_i at clear index 10, after x3 was written 0x28 earlier: the sequence restarts, ready_o rises 31 cycles after release, and x3 reads 0.
